// File: rtl/inv_pipe_if.sv
// inv_pipe_if: valid/ready bundle for inv_pipe. It carries the input beat (in_valid/in_ready/op/a/b)
// and the result beat (out_valid/out_ready/y).
// slave  = the inv_pipe block itself (consumes operands, produces results).
// master = the surrounding environment (offers operands, accepts results).
interface inv_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/inv_pipe.sv
// inv_pipe: selectable bitwise op (NOT/AND/OR/XOR, complements, pass) on WIDTH-bit operands.
// Latency 1 clock. A 2-entry skid buffer gives full throughput, and in_ready comes straight from a flop.
// Backpressure: in_ready drops the cycle after the skid entry fills. At most 2 results are held.
// Ports: clk, reset (sync, active-high), bus (inv_pipe_if.slave), clr (sync count clear),
//        count (completed output beats, modulo 2^CNT_W).
module inv_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    inv_pipe_if.slave        bus,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    // The state encoding is {out_valid, skid_valid}, so both flags come directly from state bits.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_y;
    logic [WIDTH-1:0] skid_y;
    logic [WIDTH-1:0] result;
    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             out_fire;
    logic             load_main_new;
    logic             load_main_skid;
    logic             load_skid;

    assign in_ready  = ~state[0];
    assign out_valid = state[1];
    assign accept    = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.y         = main_y;

    // The result is computed at acceptance and only the result is stored. Operands are never kept.
    always_comb begin
        result = '0;
        case (bus.op)
            3'b000:  result = ~bus.a;
            3'b001:  result = bus.a & bus.b;
            3'b010:  result = bus.a | bus.b;
            3'b011:  result = bus.a ^ bus.b;
            3'b100:  result = ~(bus.a & bus.b);
            3'b101:  result = ~(bus.a | bus.b);
            3'b110:  result = ~(bus.a ^ bus.b);
            default: result = bus.a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt     = ONE;
                    load_main_new = 1'b1;
                end
            end
            ONE: begin
                if (out_fire && accept) begin
                    load_main_new = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end else if (accept) begin
                    // Main is stalled, so the new result goes into the skid entry.
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end
            end
            FULL: begin
                // in_ready is low here, so no accept can coincide with the drain.
                if (out_fire) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_y <= '0;
            skid_y <= '0;
        end else begin
            if (load_main_new) begin
                main_y <= result;
            end else if (load_main_skid) begin
                main_y <= skid_y;
            end
            if (load_skid) begin
                skid_y <= result;
            end
        end
    end

    // clr takes priority over a same-cycle out_fire.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (out_fire) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule
